// File: rtl/spi_arbiter.sv
// Round-robin arbiter sharing one SPI master among NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to enable the WAIT-state watchdog (TIMEOUT_CYCLES).
module spi_arbiter #(
  parameter int DATA_BITS      = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*DATA_BITS-1:0] tx_word,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [DATA_BITS-1:0]         rx_word,
  output logic                         err,
  output logic                         m_start,
  output logic [DATA_BITS-1:0]         m_tx,
  output logic [$clog2(NUM_REQ)-1:0]   m_ss_sel,
  input  logic                         m_busy,
  input  logic                         m_done,
  input  logic [DATA_BITS-1:0]         m_rx
);
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t               state_reg;
  logic [PW-1:0]        rr_ptr_reg;
  logic [PW-1:0]        cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0]   cand_hit;
  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [DATA_BITS-1:0] win_word;
  logic                 timeout_hit;

  // Candidate gi is the requester gi positions after rr_ptr, wrapped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum          = {1'b0, rr_ptr_reg} + (PW+1)'(gi);
      assign cand_idx[gi] = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Scan from the farthest candidate down so the nearest one wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (cand_hit[k]) begin
        win_found = 1'b1;
        win_idx   = cand_idx[k];
      end
    end
  end

  assign win_word = tx_word[win_idx*DATA_BITS +: DATA_BITS];

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] to_cnt_reg;

  assign timeout_hit = (state_reg == WAIT) && (to_cnt_reg == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_reg <= '0;
      err        <= 1'b0;
    end else begin
      err <= (state_reg == WAIT) && !m_done && timeout_hit;
      if (state_reg != WAIT || m_done)
        to_cnt_reg <= '0;
      else if (!timeout_hit)
        to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      grant      <= '0;
      rsp_valid  <= '0;
      rx_word    <= '0;
      m_start    <= 1'b0;
      m_tx       <= '0;
      m_ss_sel   <= '0;
      rr_ptr_reg <= '0;
    end else begin
      m_start <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant     <= NUM_REQ'(1) << win_idx;
            m_ss_sel  <= win_idx;
            m_tx      <= win_word;
            state_reg <= START;
          end
        end
        START: begin
          if (!m_busy) begin
            m_start   <= 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (m_done) begin
            rx_word   <= m_rx;
            rsp_valid <= grant;
            state_reg <= RESP;
          end else if (timeout_hit) begin
            rx_word   <= '0;
            rsp_valid <= grant;
            state_reg <= RESP;
          end
        end
        RESP: begin
          rsp_valid  <= '0;
          grant      <= '0;
          rr_ptr_reg <= (m_ss_sel == PW'(NUM_REQ - 1)) ? '0 : m_ss_sel + PW'(1);
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 8, SPI word width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, WAIT-state watchdog limit (used only with SPI_ARB_TIMEOUT_EN).
REQ-004 Port clk  input  1  single clock, all state on rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port req  input  NUM_REQ  per-requester transaction request, level.
REQ-007 Port tx_word  input  NUM_REQ*DATA_BITS  packed TX words, requester i at [i*DATA_BITS +: DATA_BITS].
REQ-008 Port grant  output  NUM_REQ  one-hot current owner, zero when idle.
REQ-009 Port rsp_valid  output  NUM_REQ  one-cycle completion pulse to owner.
REQ-010 Port rx_word  output  DATA_BITS  received word, valid with rsp_valid.
REQ-011 Port err  output  1  timeout flag, pulses with rsp_valid.
REQ-012 Port m_start  output  1  one-cycle start strobe to SPI master.
REQ-013 Port m_tx  output  DATA_BITS  word to transmit, stable from m_start until m_done.
REQ-014 Port m_ss_sel  output  $clog2(NUM_REQ)  slave-select index (= owner index).
REQ-015 Port m_busy  input  1  SPI master busy.
REQ-016 Port m_done  input  1  SPI master one-cycle completion pulse.
REQ-017 Port m_rx  input  DATA_BITS  SPI master received word, valid with m_done.

Function
REQ-018 The FSM SHALL have states IDLE, START, WAIT, RESP.
REQ-019 In IDLE with any req high, the block SHALL pick the winner round-robin starting at pointer rr_ptr, register grant, m_ss_sel, m_tx = winner's tx_word, and enter START next cycle.
REQ-020 In START, m_start SHALL pulse exactly one cycle when m_busy is low, then go to WAIT; with m_busy high it SHALL hold START, m_start low.
REQ-021 In WAIT, on m_done the block SHALL capture m_rx into rx_word and go to RESP; m_done outside WAIT SHALL be ignored.
REQ-022 In RESP, rsp_valid[owner] SHALL pulse one cycle, grant SHALL clear the following cycle, rr_ptr SHALL become (owner+1) mod NUM_REQ, FSM returns to IDLE.
REQ-023 Latency req-to-m_start SHALL be 2 cycles with m_busy low; m_done-to-rsp_valid 1 cycle.
REQ-024 Deasserting req after grant SHALL NOT abort the transaction; requester is served to completion.
REQ-025 A requester holding req after rsp_valid SHALL NOT be re-granted while another requester's req is high (fairness).
REQ-026 Simultaneous requests SHALL be resolved by lowest index at or after rr_ptr, wrapping at NUM_REQ-1 to 0.
REQ-027 At most one grant bit SHALL be high at any time; tx_word changes after grant SHALL NOT affect m_tx.

Reset
REQ-028 On reset low, immediately: state IDLE, grant 0, rsp_valid 0, rx_word 0, err 0, m_start 0, m_tx 0, m_ss_sel 0, rr_ptr 0, timeout counter 0.
REQ-029 Reset mid-transaction SHALL abandon it with no rsp_valid; first grant after release SHALL follow REQ-019 with rr_ptr 0.

Configuration
REQ-030 With macro SPI_ARB_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYCLES without m_done SHALL enter RESP with rx_word = 0 and err = 1 for the rsp_valid cycle.
REQ-031 Without SPI_ARB_TIMEOUT_EN, err SHALL be tied 0, no counter logic, WAIT holds indefinitely.

Verification
REQ-032 Single req[0], tx_word0=8'hFA, model returns 8'hA5 after 20 cycles -> m_start 2 cycles after req, m_tx=FA, m_ss_sel=0, rsp_valid[0] with rx_word=A5.
REQ-033 req=4'b1111 held, words FA/FB/FC/FE -> grants in order 0,1,2,3,0, one m_start each, no overlap.
REQ-034 m_busy high 5 cycles during START -> m_start delayed until m_busy low, single pulse.
REQ-035 reset low during WAIT -> all outputs 0 immediately, no rsp_valid; after release req[2] granted normally.
REQ-036 SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, model never sends m_done -> rsp_valid and err high 17 cycles after m_start, rx_word=0.
REQ-037 req[1] dropped one cycle after grant -> transaction completes, rsp_valid[1] pulses.
